reg_file_np: RTL and testbench
==============================

// Module: reg_file_np
// PURPOSE
//  Parametrised CPU register file: generalises the single 16-bit load register
//  to DEPTH words of WIDTH bits, with one write port and two read ports.
//  Sits between decode (read addresses) and writeback (write port) in the
//  basic-cpu datapath.
//  Adds synchronous reset, an optional hardwired-zero R0, write-to-read bypass
//  and an optional registered-read mode.
// PARAMETERS
//  WIDTH     16  data width, bits (>=1)
//  DEPTH     8   number of registers (power of 2, >=2)
//  ZERO_R0   1   1: R0 reads 0 and ignores writes; 0: R0 is an ordinary register
//  READ_REG  0   0: combinational read (0-cycle latency); 1: registered read (1 cycle)
//  AW        $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  clk     in   1      single clock; all state updates on the rising edge
//  rst     in   1      synchronous reset, active-high
//  load    in   1      write enable for the write port
//  waddr   in   AW     write address
//  vecin   in   WIDTH  write data
//  raddr_a in   AW     read port A address
//  raddr_b in   AW     read port B address
//  re      in   1      read enable; used only when READ_REG=1
//  vecout_a out WIDTH  read port A data
//  vecout_b out WIDTH  read port B data
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge clears every register to 0. When READ_REG=1
//    it also clears vecout_a/vecout_b to 0. rst has priority over load and re.
//    A write presented in a reset cycle is discarded.
//  - Write: load=1 and rst=0 at an edge stores vecin into regs[waddr].
//    - Exception: ZERO_R0=1 and waddr=0, where the write is dropped silently.
//    - load=0 leaves all registers unchanged (hold).
//  - Read, READ_REG=0:
//    - vecout_x = regs[raddr_x] combinationally; no bypass.
//    - A write becomes visible the cycle after its edge.
//  - Read, READ_REG=1:
//    - At an edge with re=1 and rst=0, vecout_x <= selected data.
//    - Selected data is vecin when load=1, waddr==raddr_x and the target is not
//      a zero R0 (write-first bypass). Otherwise it is regs[raddr_x].
//    - re=0 holds both outputs.
//  - R0 with ZERO_R0=1 always reads 0 on both ports, bypass included.
//  - Both ports may address the same register; each port returns identical data.
//  - Addresses are never out of range, because DEPTH is a power of 2.
//  - Reset mid-stream: the register contents and any registered outputs are
//    zero on the first edge where rst=1. Normal operation resumes on the first
//    edge after rst falls.
//  - No X propagation from unwritten registers: every register is written at reset.
// STRUCTURE
//  - Package cpu_pkg holds the shared constants: CPU_WIDTH=16, CPU_NREGS=8 and
//    CPU_AW=3. It also holds the typedef word_t = logic [CPU_WIDTH-1:0]. The
//    top level instantiates the block with these.
//  - Sub-module rf_read_port holds one port's read mux, zero-R0 masking, bypass
//    and the optional output register. It is instantiated twice (ports A and B).
//    Storage and write decode stay in reg_file_np.
// TESTING (clk period 20 ns, WIDTH=16, DEPTH=8)
//  1. rst=1 for 1 edge, then read all 8 addresses on both ports -> 16'h0000 everywhere.
//  2. Write R3 = 16'h000F (load=1), then load=0 with vecin=16'h0000 for 2 edges
//     -> R3 holds 16'h000F (the hold behaviour of the old reg16).
//  3. ZERO_R0=1: write R0 = 16'hFFFF -> vecout_a reads 16'h0000.
//     Repeat with ZERO_R0=0 -> 16'hFFFF.
//  4. READ_REG=1: in a single cycle set load=1, waddr=5, vecin=16'hA5A5,
//     raddr_a=5 and re=1 -> vecout_a=16'hA5A5 after that edge (bypass).
//     raddr_b=5 in the same cycle gives the same result.
//  5. Write R2 = 16'h1234, then assert rst together with load=1, waddr=2,
//     vecin=16'hBEEF -> R2 reads 16'h0000. With READ_REG=1, the outputs are 0.
//  6. Write all 8 registers with value 16'h1111*i. Then read ports A and B with
//     mismatched address sweeps -> every port returns the value written
//     (R0 returns 0 when ZERO_R0=1).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants for the basic-cpu register file and its neighbours.
package cpu_pkg;
   localparam int CPU_WIDTH = 16;
   localparam int CPU_NREGS = 8;
   localparam int CPU_AW    = 3;

   typedef logic [CPU_WIDTH-1:0] word_t;
endpackage

// File: rtl/reg_file_np_if.sv
// Register-file bus: writeback drives the write port, decode drives the read addresses.
interface reg_file_np_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH,
   parameter int AW    = CPU_AW
);
   logic             load;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] vecin;
   logic [AW-1:0]    raddr_a;
   logic [AW-1:0]    raddr_b;
   logic             re;
   logic [WIDTH-1:0] vecout_a;
   logic [WIDTH-1:0] vecout_b;

   modport master (output load, waddr, vecin, raddr_a, raddr_b, re,
                   input  vecout_a, vecout_b);
   modport slave  (input  load, waddr, vecin, raddr_a, raddr_b, re,
                   output vecout_a, vecout_b);
endinterface

// File: rtl/reg_file_np_read_port.sv
// One read port: address mux, zero-R0 masking, write-first bypass and the
// optional output register.
module rf_read_port #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter bit ZERO_R0  = 1'b1,
   parameter bit READ_REG = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DEPTH-1:0][WIDTH-1:0] regs,
   input  logic [AW-1:0]               raddr,
   input  logic                        load,
   input  logic [AW-1:0]               waddr,
   input  logic [WIDTH-1:0]            vecin,
   input  logic                        re,
   output logic [WIDTH-1:0]            dout
);
   logic             zero_hit;
   logic             byp;
   logic [WIDTH-1:0] rd;

   assign zero_hit = ZERO_R0 && (raddr == '0);
   assign rd       = zero_hit ? '0 : regs[raddr];
   // Bypass never fires on a zero R0, so R0 stays 0 even on a same-cycle write.
   assign byp      = load && (waddr == raddr) && !zero_hit;

   generate
      if (READ_REG) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst)     dout <= '0;
            else if (re) dout <= byp ? vecin : rd;
         end
      end else begin : g_comb
         logic unused_ok;
         assign unused_ok = ^{clk, rst, re, byp, vecin};
         assign dout      = rd;
      end
   endgenerate
endmodule

// File: rtl/reg_file_np.sv
// DEPTH x WIDTH register file, one write port and two read ports (A, B).
module reg_file_np
   import cpu_pkg::*;
#(
   parameter int WIDTH    = CPU_WIDTH,
   parameter int DEPTH    = CPU_NREGS,
   parameter bit ZERO_R0  = 1'b1,
   parameter bit READ_REG = 1'b0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_np_if.slave  bus
);
   localparam int NPORTS = 2;

   logic [DEPTH-1:0][WIDTH-1:0]  regs;
   logic [NPORTS-1:0][AW-1:0]    raddr;
   logic [NPORTS-1:0][WIDTH-1:0] dout;
   logic                         wr_en;

   assign wr_en = bus.load && !(ZERO_R0 && (bus.waddr == '0));

   // Reset wins over load, so a write in a reset cycle is discarded.
   always_ff @(posedge clk) begin
      if (rst)        regs <= '0;
      else if (wr_en) regs[bus.waddr] <= bus.vecin;
   end

   assign raddr = {bus.raddr_b, bus.raddr_a};

   generate
      for (genvar p = 0; p < NPORTS; p++) begin : g_port
         rf_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_R0  (ZERO_R0),
            .READ_REG (READ_REG)
         ) u_port (
            .clk   (clk),
            .rst   (rst),
            .regs  (regs),
            .raddr (raddr[p]),
            .load  (bus.load),
            .waddr (bus.waddr),
            .vecin (bus.vecin),
            .re    (bus.re),
            .dout  (dout[p])
         );
      end
   endgenerate

   assign bus.vecout_a = dout[0];
   assign bus.vecout_b = dout[1];
endmodule

// File: tb/tb_reg_file_np.sv
// Directed bench: three configurations share one stimulus stream
// (0: zero R0 comb, 1: plain R0 comb, 2: zero R0 registered read).
module tb_reg_file_np;
   import cpu_pkg::*;

   logic          clk;
   logic          rst;
   logic          load;
   logic [2:0]    waddr;
   word_t         vecin;
   logic [2:0]    raddr_a;
   logic [2:0]    raddr_b;
   logic          re;
   logic [2:0][15:0] va;
   logic [2:0][15:0] vb;

   int nvec = 0;
   int nmis = 0;

   generate
      for (genvar g = 0; g < 3; g++) begin : cfg
         reg_file_np_if #(.WIDTH(16), .AW(3)) bus ();
         assign bus.load    = load;
         assign bus.waddr   = waddr;
         assign bus.vecin   = vecin;
         assign bus.raddr_a = raddr_a;
         assign bus.raddr_b = raddr_b;
         assign bus.re      = re;
         assign va[g]       = bus.vecout_a;
         assign vb[g]       = bus.vecout_b;

         reg_file_np #(
            .WIDTH    (16),
            .DEPTH    (8),
            .ZERO_R0  (g != 1),
            .READ_REG (g == 2)
         ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      word_t exp;
      rst = 1'b1; load = 1'b1; waddr = 3'd1; vecin = 16'hFFFF; re = 1'b1;
      step();
      rst = 1'b0; load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         raddr_a = 3'(i);
         raddr_b = 3'(7 - i);
         step();
         exp = 16'h0000;
         for (int g = 0; g < 3; g++) begin
            nvec++;
            if (va[g] !== exp) begin
               nmis++;
               $display("FAIL reset_a cfg%0d r%0d: got %h want %h", g, i, va[g], exp);
            end
            nvec++;
            if (vb[g] !== exp) begin
               nmis++;
               $display("FAIL reset_b cfg%0d r%0d: got %h want %h", g, 7 - i, vb[g], exp);
            end
         end
      end
   endtask

   task automatic test_hold();
      load = 1'b1; waddr = 3'd3; vecin = 16'h000F; raddr_a = 3'd3; raddr_b = 3'd0; re = 1'b0;
      #1;
      nvec++;
      if (va[0] !== 16'h0000) begin
         nmis++;
         $display("FAIL comb_no_bypass: got %h want %h", va[0], 16'h0000);
      end
      step();
      load = 1'b0; vecin = 16'h0000; re = 1'b1;
      #1;
      nvec++;
      if (va[1] !== 16'h000F) begin
         nmis++;
         $display("FAIL write_visible: got %h want %h", va[1], 16'h000F);
      end
      step();
      step();
      for (int g = 0; g < 3; g++) begin
         nvec++;
         if (va[g] !== 16'h000F) begin
            nmis++;
            $display("FAIL hold_r3 cfg%0d: got %h want %h", g, va[g], 16'h000F);
         end
      end
   endtask

   task automatic test_zero_r0();
      load = 1'b1; waddr = 3'd0; vecin = 16'hFFFF; raddr_a = 3'd0; raddr_b = 3'd0; re = 1'b1;
      step();
      load = 1'b0;
      #1;
      nvec++;
      if (va[0] !== 16'h0000) begin
         nmis++;
         $display("FAIL zero_r0_comb: got %h want %h", va[0], 16'h0000);
      end
      nvec++;
      if (va[1] !== 16'hFFFF) begin
         nmis++;
         $display("FAIL plain_r0_a: got %h want %h", va[1], 16'hFFFF);
      end
      nvec++;
      if (vb[1] !== 16'hFFFF) begin
         nmis++;
         $display("FAIL plain_r0_b: got %h want %h", vb[1], 16'hFFFF);
      end
      nvec++;
      if (va[2] !== 16'h0000 || vb[2] !== 16'h0000) begin
         nmis++;
         $display("FAIL zero_r0_bypass: got %h/%h want %h", va[2], vb[2], 16'h0000);
      end
   endtask

   task automatic test_bypass();
      load = 1'b1; waddr = 3'd5; vecin = 16'hA5A5; raddr_a = 3'd5; raddr_b = 3'd5; re = 1'b1;
      step();
      load = 1'b0; vecin = 16'h0000;
      nvec++;
      if (va[2] !== 16'hA5A5) begin
         nmis++;
         $display("FAIL bypass_a: got %h want %h", va[2], 16'hA5A5);
      end
      nvec++;
      if (vb[2] !== 16'hA5A5) begin
         nmis++;
         $display("FAIL bypass_b: got %h want %h", vb[2], 16'hA5A5);
      end
      re = 1'b0; raddr_a = 3'd3;
      step();
      nvec++;
      if (va[2] !== 16'hA5A5) begin
         nmis++;
         $display("FAIL re_hold: got %h want %h", va[2], 16'hA5A5);
      end
      nvec++;
      if (va[0] !== 16'h000F) begin
         nmis++;
         $display("FAIL comb_r3: got %h want %h", va[0], 16'h000F);
      end
   endtask

   task automatic test_reset_mid();
      load = 1'b1; waddr = 3'd2; vecin = 16'h1234; re = 1'b0;
      step();
      load = 1'b0; raddr_a = 3'd2;
      #1;
      nvec++;
      if (va[0] !== 16'h1234) begin
         nmis++;
         $display("FAIL r2_write: got %h want %h", va[0], 16'h1234);
      end
      rst = 1'b1; load = 1'b1; waddr = 3'd2; vecin = 16'hBEEF; re = 1'b1; raddr_b = 3'd3;
      step();
      rst = 1'b0; load = 1'b0;
      nvec++;
      if (va[2] !== 16'h0000 || vb[2] !== 16'h0000) begin
         nmis++;
         $display("FAIL rst_regout: got %h/%h want %h", va[2], vb[2], 16'h0000);
      end
      for (int g = 0; g < 2; g++) begin
         nvec++;
         if (va[g] !== 16'h0000) begin
            nmis++;
            $display("FAIL rst_r2 cfg%0d: got %h want %h", g, va[g], 16'h0000);
         end
         nvec++;
         if (vb[g] !== 16'h0000) begin
            nmis++;
            $display("FAIL rst_r3 cfg%0d: got %h want %h", g, vb[g], 16'h0000);
         end
      end
   endtask

   task automatic test_back_to_back();
      word_t exp;
      logic [2:0] ab;
      for (int i = 0; i < 8; i++) begin
         load = 1'b1; waddr = 3'(i); vecin = 16'(16'h1111 * i);
         raddr_a = 3'(i); raddr_b = 3'(i); re = 1'b1;
         step();
         exp = (i == 0) ? 16'h0000 : 16'(16'h1111 * i);
         nvec++;
         if (va[2] !== exp) begin
            nmis++;
            $display("FAIL b2b_bypass r%0d: got %h want %h", i, va[2], exp);
         end
      end
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         raddr_a = 3'(i);
         ab      = 3'((i + 5) % 8);
         raddr_b = ab;
         step();
         for (int g = 0; g < 3; g++) begin
            exp = (i == 0 && g != 1) ? 16'h0000 : 16'(16'h1111 * i);
            nvec++;
            if (va[g] !== exp) begin
               nmis++;
               $display("FAIL sweep_a cfg%0d r%0d: got %h want %h", g, i, va[g], exp);
            end
            exp = (ab == 3'd0 && g != 1) ? 16'h0000 : 16'(16'h1111 * ab);
            nvec++;
            if (vb[g] !== exp) begin
               nmis++;
               $display("FAIL sweep_b cfg%0d r%0d: got %h want %h", g, ab, vb[g], exp);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; load = 1'b0; waddr = '0; vecin = '0;
      raddr_a = '0; raddr_b = '0; re = 1'b0;
      #1;
      test_reset();
      test_hold();
      test_zero_r0();
      test_bypass();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
